alu_operand_stage: RTL

- ID/EX pipeline stage feeding the execute ALU.
- Captures decoded instructions and resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards, inserts bubbles and supports flush.
- Presents registered operands, opcode and shift amount on the ALU input ports through a valid/ready handshake.

---
 rtl/alu_stage_pkg.sv | 25 ++
 rtl/alu_operand_stage_operand_forward_mux.sv | 43 ++++
 rtl/alu_operand_stage.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/alu_stage_pkg.sv
// Shared constants and types for the ALU operand stage.
//   DATA_W / REG_AW : default operand and register-address widths
//   REG_ZERO        : the hardwired-zero register address
//   OP_*            : ALU opcode encodings carried on ctrl_ALUopcode
//   stage_state_e   : stage occupancy (EMPTY / FULL), mirrored on out_valid
package alu_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_AND = 5'b00010;
  localparam logic [4:0] OP_OR  = 5'b00011;
  localparam logic [4:0] OP_SLL = 5'b00100;
  localparam logic [4:0] OP_SRA = 5'b00101;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_e;

endpackage

// File: rtl/alu_operand_stage_operand_forward_mux.sv
// operand_forward_mux: combinational operand selection for one ALU source.
// Priority: immediate (when i_use_imm), r0 -> 0, EX/MEM match, MEM/WB match,
// then the register-file value. The stage also reuses it to refresh a held
// operand from MEM/WB by feeding the held value in as i_rf_data.
// Ports:
//   i_addr                  source register address
//   i_rf_data               register-file (or held) value
//   i_use_imm, i_imm        select the immediate instead of a register
//   i_exmem_we/_rd/_data    EX/MEM writeback candidate
//   i_memwb_we/_rd/_data    MEM/WB writeback
//   o_data                  resolved operand
module operand_forward_mux #(
  parameter int DATA_W = alu_stage_pkg::DATA_W,
  parameter int REG_AW = alu_stage_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] i_addr,
  input  logic [DATA_W-1:0] i_rf_data,
  input  logic              i_use_imm,
  input  logic [DATA_W-1:0] i_imm,
  input  logic              i_exmem_we,
  input  logic [REG_AW-1:0] i_exmem_rd,
  input  logic [DATA_W-1:0] i_exmem_data,
  input  logic              i_memwb_we,
  input  logic [REG_AW-1:0] i_memwb_rd,
  input  logic [DATA_W-1:0] i_memwb_data,
  output logic [DATA_W-1:0] o_data
);
  import alu_stage_pkg::*;

  always_comb begin
    o_data = i_rf_data;
    if (i_use_imm) begin
      o_data = i_imm;
    end else if (i_addr == REG_AW'(REG_ZERO)) begin
      o_data = '0;
    end else if (i_exmem_we && (i_exmem_rd == i_addr)) begin
      o_data = i_exmem_data;
    end else if (i_memwb_we && (i_memwb_rd == i_addr)) begin
      o_data = i_memwb_data;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: ID/EX register feeding the execute ALU.
// Captures decoded instructions, forwards from EX/MEM and MEM/WB, stalls on
// load-use hazards and supports flush.
//
// Handshake: a beat moves on a rising edge when valid && ready are both high
// at that edge; a valid output holds all its fields stable until accepted.
// The one exception is a held operand being refreshed by a MEM/WB write to
// its source register while the stage waits on out_ready.
//
// Optional build macro ALU_STAGE_PERF_EN adds perf_stall_count, the number
// of cycles an instruction was held back by a load-use hazard.
//
// Ports:
//   clock, reset (async, active low)
//   in_valid/in_ready + in_* decoded instruction fields
//   exmem_*, memwb_*     writeback candidates for forwarding
//   flush                kill held and incoming instruction
//   out_valid/out_ready  ALU-side handshake; out_valid is the FSM state
//   data_operandA/B, ctrl_ALUopcode, ctrl_shiftamt, out_rd_addr, out_is_load
//   perf_stall_count     (ALU_STAGE_PERF_EN only)
module alu_operand_stage #(
  parameter int DATA_W = alu_stage_pkg::DATA_W,
  parameter int REG_AW = alu_stage_pkg::REG_AW
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_opcode,
  input  logic [4:0]        in_shiftamt,
  input  logic [REG_AW-1:0] in_rs_addr,
  input  logic [REG_AW-1:0] in_rt_addr,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_use_imm,
  input  logic [REG_AW-1:0] in_rd_addr,
  input  logic              in_is_load,
  input  logic              exmem_we,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_data,
  input  logic              memwb_we,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_operandA,
  output logic [DATA_W-1:0] data_operandB,
  output logic [4:0]        ctrl_ALUopcode,
  output logic [4:0]        ctrl_shiftamt,
  output logic [REG_AW-1:0] out_rd_addr,
  output logic              out_is_load
`ifdef ALU_STAGE_PERF_EN
  ,
  output logic [31:0]       perf_stall_count
`endif
);
  import alu_stage_pkg::*;

  stage_state_e r_state;
  stage_state_e w_state_nxt;

  logic [DATA_W-1:0] r_op_a;
  logic [DATA_W-1:0] r_op_b;
  logic [4:0]        r_opcode;
  logic [4:0]        r_shamt;
  logic [REG_AW-1:0] r_rd;
  logic              r_is_load;
  // Source addresses are kept so a stalled operand can still pick up MEM/WB.
  logic [REG_AW-1:0] r_rs_addr;
  logic [REG_AW-1:0] r_rt_addr;
  logic              r_use_imm;

  logic              w_adv;
  logic              w_lu;
  logic              w_capture;
  logic              w_hold;
  logic [DATA_W-1:0] w_fwd_a;
  logic [DATA_W-1:0] w_fwd_b;

  always_comb begin
    w_adv       = (r_state == ST_EMPTY) || out_ready;
    w_lu        = (r_state == ST_FULL) && r_is_load && (r_rd != '0) && in_valid &&
                  ((r_rd == in_rs_addr) || (!in_use_imm && (r_rd == in_rt_addr)));
    // Flush forces ready so the incoming instruction is consumed and dropped.
    in_ready    = flush || (w_adv && !w_lu);
    w_capture   = in_valid && in_ready && !flush;
    w_hold      = (r_state == ST_FULL) && !out_ready && !flush;
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else if (w_capture) begin
      w_state_nxt = ST_FULL;
    end else if (w_adv) begin
      w_state_nxt = ST_EMPTY;   // bubble: payload registers keep their contents
    end
  end

  // While holding, the muxes see the held operand as "register file" data and
  // only MEM/WB can override it (EX/MEM is masked off).
  operand_forward_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_a (
    .i_addr       (w_hold ? r_rs_addr : in_rs_addr),
    .i_rf_data    (w_hold ? r_op_a : in_rs_data),
    .i_use_imm    (1'b0),
    .i_imm        ('0),
    .i_exmem_we   (exmem_we && !w_hold),
    .i_exmem_rd   (exmem_rd),
    .i_exmem_data (exmem_data),
    .i_memwb_we   (memwb_we),
    .i_memwb_rd   (memwb_rd),
    .i_memwb_data (memwb_data),
    .o_data       (w_fwd_a)
  );

  operand_forward_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_b (
    .i_addr       (w_hold ? r_rt_addr : in_rt_addr),
    .i_rf_data    (w_hold ? r_op_b : in_rt_data),
    .i_use_imm    (w_hold ? r_use_imm : in_use_imm),
    .i_imm        (w_hold ? r_op_b : in_imm),
    .i_exmem_we   (exmem_we && !w_hold),
    .i_exmem_rd   (exmem_rd),
    .i_exmem_data (exmem_data),
    .i_memwb_we   (memwb_we),
    .i_memwb_rd   (memwb_rd),
    .i_memwb_data (memwb_data),
    .o_data       (w_fwd_b)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_opcode  <= '0;
      r_shamt   <= '0;
      r_rd      <= '0;
      r_is_load <= 1'b0;
      r_rs_addr <= '0;
      r_rt_addr <= '0;
      r_use_imm <= 1'b0;
    end else if (w_capture) begin
      r_op_a    <= w_fwd_a;
      r_op_b    <= w_fwd_b;
      r_opcode  <= in_opcode;
      r_shamt   <= in_shiftamt;
      r_rd      <= in_rd_addr;
      r_is_load <= in_is_load;
      r_rs_addr <= in_rs_addr;
      r_rt_addr <= in_rt_addr;
      r_use_imm <= in_use_imm;
    end else if (w_hold) begin
      r_op_a    <= w_fwd_a;
      r_op_b    <= w_fwd_b;
    end
  end

`ifdef ALU_STAGE_PERF_EN
  logic [31:0] r_perf_stall;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_perf_stall <= '0;
    end else if (w_lu && w_adv && !flush) begin
      r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_stall_count = r_perf_stall;
`endif

  assign out_valid      = (r_state == ST_FULL);
  assign data_operandA  = r_op_a;
  assign data_operandB  = r_op_b;
  assign ctrl_ALUopcode = r_opcode;
  assign ctrl_shiftamt  = r_shamt;
  assign out_rd_addr    = r_rd;
  assign out_is_load    = r_is_load;

endmodule
